sobel_filter: RTL

//  Stage 1 of edge_detect, directly downstream of grayscale.

---
 rtl/sobel_filter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sobel_filter.sv
// sobel_filter: streaming 3x3 Sobel magnitude between two FIFOs using two line buffers.
// Rev 1.0 - initial release.
`default_nettype none

module sobel_filter #(
   parameter int WIDTH  = 720,
   parameter int HEIGHT = 540
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] in_dout,
   input  logic       in_empty,
   output logic       in_rd_en,
   output logic [7:0] out_din,
   input  logic       out_full,
   output logic       out_wr_en,
   output logic       frame_done
);

   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam logic [CW-1:0] C_COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] C_ROW_LAST = RW'(HEIGHT - 1);

   typedef enum logic [1:0] {S_FILL = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

   state_t        r_state, w_next;
   logic [CW-1:0] r_in_col, r_out_col;
   logic [RW-1:0] r_in_row, r_out_row;
   logic [7:0]    r_lb0 [WIDTH];
   logic [7:0]    r_lb1 [WIDTH];
   logic [7:0]    r_t0, r_t1, r_m0, r_m1, r_b0, r_b1;

   logic [7:0]         w_p02, w_p12;
   logic [9:0]         w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
   logic signed [10:0] w_gx, w_gy;
   logic [10:0]        w_ax, w_ay, w_mag;
   logic [11:0]        w_sum;
   logic [7:0]         w_clamp;
   logic               w_in_last, w_out_last, w_border;

   // Right-hand window column comes straight from the line buffers and the FIFO head.
   assign w_p02 = r_lb1[r_in_col];
   assign w_p12 = r_lb0[r_in_col];

   assign w_gx_pos = {2'b0, w_p02} + {1'b0, w_p12, 1'b0} + {2'b0, in_dout};
   assign w_gx_neg = {2'b0, r_t0}  + {1'b0, r_m0, 1'b0}  + {2'b0, r_b0};
   assign w_gy_pos = {2'b0, r_b0}  + {1'b0, r_b1, 1'b0}  + {2'b0, in_dout};
   assign w_gy_neg = {2'b0, r_t0}  + {1'b0, r_t1, 1'b0}  + {2'b0, w_p02};
   assign w_gx     = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
   assign w_gy     = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});
   assign w_ax     = w_gx[10] ? 11'(-w_gx) : 11'(w_gx);
   assign w_ay     = w_gy[10] ? 11'(-w_gy) : 11'(w_gy);
   assign w_sum    = {1'b0, w_ax} + {1'b0, w_ay};
   assign w_mag    = 11'(w_sum >> 1);
   assign w_clamp  = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];

   assign w_in_last  = (r_in_row == C_ROW_LAST) && (r_in_col == C_COL_LAST);
   assign w_out_last = (r_out_row == C_ROW_LAST) && (r_out_col == C_COL_LAST);
   assign w_border   = (r_out_row == '0) || (r_out_row == C_ROW_LAST) ||
                       (r_out_col == '0) || (r_out_col == C_COL_LAST);

   always_comb begin
      w_next    = r_state;
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
      case (r_state)
         S_FILL: begin
            in_rd_en = !in_empty;
            if (in_rd_en && (r_in_row == RW'(1)) && (r_in_col == '0))
               w_next = S_RUN;
         end
         S_RUN: begin
            in_rd_en  = !in_empty && !out_full;
            out_wr_en = in_rd_en;
            if (in_rd_en && w_in_last)
               w_next = S_FLUSH;
         end
         S_FLUSH: begin
            out_wr_en = !out_full;
            if (out_wr_en && w_out_last)
               w_next = S_FILL;
         end
         default: w_next = S_FILL;
      endcase
      // Nothing may be popped or pushed while the asynchronous reset is held.
      if (!reset) begin
         in_rd_en  = 1'b0;
         out_wr_en = 1'b0;
      end
   end

   assign out_din    = (r_state == S_RUN && !w_border && reset) ? w_clamp : 8'h00;
   assign frame_done = out_wr_en && w_out_last;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= S_FILL;
         r_in_col  <= '0;
         r_in_row  <= '0;
         r_out_col <= '0;
         r_out_row <= '0;
         r_t0 <= '0; r_t1 <= '0; r_m0 <= '0; r_m1 <= '0; r_b0 <= '0; r_b1 <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            r_lb0[i] <= '0;
            r_lb1[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         if (in_rd_en) begin
            r_lb1[r_in_col] <= w_p12;
            r_lb0[r_in_col] <= in_dout;
            r_t0 <= r_t1; r_t1 <= w_p02;
            r_m0 <= r_m1; r_m1 <= w_p12;
            r_b0 <= r_b1; r_b1 <= in_dout;
            if (r_in_col == C_COL_LAST) begin
               r_in_col <= '0;
               r_in_row <= (r_in_row == C_ROW_LAST) ? '0 : r_in_row + 1'b1;
            end else begin
               r_in_col <= r_in_col + 1'b1;
            end
         end
         if (out_wr_en) begin
            if (r_out_col == C_COL_LAST) begin
               r_out_col <= '0;
               r_out_row <= (r_out_row == C_ROW_LAST) ? '0 : r_out_row + 1'b1;
            end else begin
               r_out_col <= r_out_col + 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire
